// File: rtl/dmem_access_unit.sv
// -----------------------------------------------------------------------------
// dmem_access_unit
// Memory-stage load/store sequencer between the pipeline and the data cache.
// A valid, aligned load or store is latched in IDLE (stall raised in that
// same cycle). The cache request is then held in ACCESS until dmem_resp
// arrives. COMPLETE pulses done and releases the pipeline.
// A malformed request produces a one-cycle err pulse and no cache traffic:
// misaligned, reserved funct3, or both control bits set.
// An optional response timeout also ends in err, with no done.
//
// Ports
//   clk           : clock, rising edge
//   rst           : asynchronous active-low reset
//   req_valid     : memory stage holds a valid instruction
//   dcache_read   : load control bit
//   dcache_write  : store control bit
//   funct3[2:0]   : width/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   addr[31:0]    : effective byte address
//   store_data    : rs2 value for stores
//   dmem_read     : cache read request (registered)
//   dmem_write    : cache write request (registered)
//   dmem_address  : word-aligned cache address (registered)
//   dmem_wdata    : lane-shifted store data (registered)
//   dmem_mbe[3:0] : byte enables (registered)
//   dmem_resp     : cache done strobe
//   dmem_rdata    : cache read word
//   stall         : pipeline freeze
//   load_data     : aligned, extended load result (registered)
//   done          : one-cycle completion pulse (registered)
//   err           : one-cycle fault pulse (registered)
// -----------------------------------------------------------------------------
module dmem_access_unit #(
  parameter int RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        dcache_read,
  input  logic        dcache_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] TIMEOUT_C  = 8'(RESP_TIMEOUT);
  localparam logic       TIMEOUT_EN = (RESP_TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_dmem_read, w_dmem_read_nxt;
  logic        r_dmem_write, w_dmem_write_nxt;
  logic [31:0] r_dmem_address, w_dmem_address_nxt;
  logic [31:0] r_dmem_wdata, w_dmem_wdata_nxt;
  logic [3:0]  r_dmem_mbe, w_dmem_mbe_nxt;
  logic [31:0] r_load_data, w_load_data_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic [2:0]  r_funct3, w_funct3_nxt;
  logic [1:0]  r_addr_lo, w_addr_lo_nxt;

  logic        w_idle;
  logic        w_one_op;
  logic        w_any_op;
  logic        w_reserved;
  logic        w_misaligned;
  logic        w_accept;
  logic        w_bad;
  logic [3:0]  w_mbe;
  logic [31:0] w_wdata;
  logic [7:0]  w_cnt_inc;
  logic        w_timeout;

  // Select the addressed byte/half of the returned word and extend it.
  function automatic logic [31:0] f_load_extend(input logic [31:0] word,
                                                input logic [1:0]  lo,
                                                input logic [2:0]  f3);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (f3)
      3'b000:  f_load_extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  f_load_extend = {{16{sh[15]}}, sh[15:0]};
      3'b100:  f_load_extend = {24'h000000, sh[7:0]};
      3'b101:  f_load_extend = {16'h0000, sh[15:0]};
      default: f_load_extend = sh;
    endcase
  endfunction

  // Request decode. Width comes from funct3[1:0], so stores with funct3[2]
  // set behave like their unsigned-load width.
  assign w_idle       = (r_state == ST_IDLE);
  assign w_one_op     = dcache_read ^ dcache_write;
  assign w_any_op     = dcache_read | dcache_write;
  assign w_reserved   = (funct3[1:0] == 2'b11) | (funct3 == 3'b110);
  assign w_misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                        ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  // rst gates acceptance so the combinational stall is low during reset.
  assign w_accept     = rst & w_idle & req_valid & w_one_op & ~w_reserved & ~w_misaligned;
  assign w_bad        = w_idle & req_valid & w_any_op & (~w_one_op | w_reserved | w_misaligned);
  assign w_wdata      = store_data << {addr[1:0], 3'b000};

  // Timeout fires on the ACCESS cycle whose count reaches RESP_TIMEOUT.
  assign w_cnt_inc    = r_cnt + 8'd1;
  assign w_timeout    = TIMEOUT_EN & (w_cnt_inc == TIMEOUT_C);

  // Byte-enable generation for the incoming request.
  always_comb begin
    w_mbe = 4'b1111;
    if (dcache_read) begin
      w_mbe = 4'b1111;
    end else begin
      case (funct3[1:0])
        2'b00:   w_mbe = 4'b0001 << addr[1:0];
        2'b01:   w_mbe = 4'b0011 << addr[1:0];
        default: w_mbe = 4'b1111;
      endcase
    end
  end

  // Next-state and next-register logic for the access FSM.
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_dmem_read_nxt    = r_dmem_read;
    w_dmem_write_nxt   = r_dmem_write;
    w_dmem_address_nxt = r_dmem_address;
    w_dmem_wdata_nxt   = r_dmem_wdata;
    w_dmem_mbe_nxt     = r_dmem_mbe;
    w_load_data_nxt    = r_load_data;
    w_funct3_nxt       = r_funct3;
    w_addr_lo_nxt      = r_addr_lo;
    w_done_nxt         = 1'b0;
    w_err_nxt          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt        = ST_ACCESS;
          w_cnt_nxt          = 8'd0;
          w_dmem_read_nxt    = dcache_read;
          w_dmem_write_nxt   = dcache_write;
          w_dmem_address_nxt = {addr[31:2], 2'b00};
          w_dmem_wdata_nxt   = w_wdata;
          w_dmem_mbe_nxt     = w_mbe;
          w_funct3_nxt       = funct3;
          w_addr_lo_nxt      = addr[1:0];
        end else if (w_bad) begin
          w_err_nxt = 1'b1;
        end else begin
          w_err_nxt = 1'b0;
        end
      end
      ST_ACCESS: begin
        // A response on the timeout cycle still completes normally.
        if (dmem_resp) begin
          w_state_nxt      = ST_COMPLETE;
          w_dmem_read_nxt  = 1'b0;
          w_dmem_write_nxt = 1'b0;
          w_done_nxt       = 1'b1;
          if (r_dmem_read) begin
            w_load_data_nxt = f_load_extend(dmem_rdata, r_addr_lo, r_funct3);
          end else begin
            w_load_data_nxt = r_load_data;
          end
        end else if (w_timeout) begin
          w_state_nxt      = ST_IDLE;
          w_dmem_read_nxt  = 1'b0;
          w_dmem_write_nxt = 1'b0;
          w_err_nxt        = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_COMPLETE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_dmem_read_nxt  = 1'b0;
        w_dmem_write_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 8'd0;
      r_dmem_read    <= 1'b0;
      r_dmem_write   <= 1'b0;
      r_dmem_address <= 32'h0000_0000;
      r_dmem_wdata   <= 32'h0000_0000;
      r_dmem_mbe     <= 4'b0000;
      r_load_data    <= 32'h0000_0000;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_funct3       <= 3'b000;
      r_addr_lo      <= 2'b00;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_dmem_read    <= w_dmem_read_nxt;
      r_dmem_write   <= w_dmem_write_nxt;
      r_dmem_address <= w_dmem_address_nxt;
      r_dmem_wdata   <= w_dmem_wdata_nxt;
      r_dmem_mbe     <= w_dmem_mbe_nxt;
      r_load_data    <= w_load_data_nxt;
      r_done         <= w_done_nxt;
      r_err          <= w_err_nxt;
      r_funct3       <= w_funct3_nxt;
      r_addr_lo      <= w_addr_lo_nxt;
    end
  end

  assign dmem_read    = r_dmem_read;
  assign dmem_write   = r_dmem_write;
  assign dmem_address = r_dmem_address;
  assign dmem_wdata   = r_dmem_wdata;
  assign dmem_mbe     = r_dmem_mbe;
  assign load_data    = r_load_data;
  assign done         = r_done;
  assign err          = r_err;
  assign stall        = w_accept | (r_state == ST_ACCESS);

endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 SHALL have parameter RESP_TIMEOUT, default 255, which is the maximum number of cycles to wait for dmem_resp; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: the memory stage holds a valid instruction.
REQ-005 SHALL have port dcache_read, input, 1 bit: load control bit from the decoded control word.
REQ-006 SHALL have port dcache_write, input, 1 bit: store control bit from the decoded control word.
REQ-007 SHALL have port funct3, input, 3 bits: load/store width and sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-008 SHALL have port addr, input, 32 bits: effective byte address (ALU output).
REQ-009 SHALL have port store_data, input, 32 bits: rs2 value.
REQ-010 SHALL have ports dmem_read and dmem_write, outputs, 1 bit each: cache requests.
REQ-011 SHALL have port dmem_address, output, 32 bits: {addr[31:2],2'b00}.
REQ-012 SHALL have port dmem_wdata, output, 32 bits: store data shifted into its byte lane(s).
REQ-013 SHALL have port dmem_mbe, output, 4 bits: byte enables.
REQ-014 SHALL have ports dmem_resp (input, 1 bit: cache done) and dmem_rdata (input, 32 bits: read word).
REQ-015 SHALL have port stall, output, 1 bit: freeze the pipeline.
REQ-016 SHALL have port load_data, output, 32 bits: aligned and extended load result.
REQ-017 SHALL have ports done (output, 1 bit: one-cycle completion pulse) and err (output, 1 bit: one-cycle fault pulse).

Function
REQ-018 SHALL implement the FSM states IDLE, ACCESS, and COMPLETE.
REQ-019 SHALL, in IDLE, when req_valid and exactly one of dcache_read/dcache_write is high and the access is aligned, register addr/funct3/data, move to ACCESS next cycle, and assert stall combinationally in that same cycle.
REQ-020 SHALL treat alignment as: byte always legal; half requires addr[0]=0; word requires addr[1:0]=00.
REQ-021 SHALL, for a misaligned access, a reserved funct3 (011, 110, 111), or dcache_read and dcache_write both high, issue no cache request, pulse err for one cycle, leave stall low, and stay in IDLE.
REQ-022 SHALL, in ACCESS, hold dmem_read or dmem_write and dmem_address/dmem_wdata/dmem_mbe constant from registered values, with stall=1.
REQ-023 SHALL set byte enables: sb gives 4'b0001<<addr[1:0]; sh gives 4'b0011<<addr[1:0]; sw gives 4'b1111; loads give 4'b1111.
REQ-024 SHALL form dmem_wdata as store_data<<(8*addr[1:0]).
REQ-025 SHALL, on dmem_resp in ACCESS, drop dmem_read/dmem_write next cycle, capture the load result into load_data, and go to COMPLETE.
REQ-026 SHALL form load_data by selecting the byte/half at addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word through; stores leave load_data unchanged.
REQ-027 SHALL, in COMPLETE, pulse done for one cycle with stall=0, return to IDLE, and hold load_data until the next load completes.
REQ-028 SHALL give minimum latency of request cycle to done of 3 cycles with dmem_resp on the first ACCESS cycle.
REQ-029 SHALL keep an 8-bit cycle counter in ACCESS; when RESP_TIMEOUT≠0 and the count reaches RESP_TIMEOUT without dmem_resp, drop the request, pulse err, and go to IDLE (no done).
REQ-030 SHALL ignore dmem_resp outside ACCESS.
REQ-031 SHALL not accept a new request in ACCESS or COMPLETE; a request in COMPLETE is taken in the following IDLE cycle.
REQ-032 SHALL treat req_valid with both control bits low as a no-op: no stall, no pulses.

Reset
REQ-033 SHALL, while rst=0, force state IDLE, counter 0, and dmem_read=dmem_write=0, dmem_address=0, dmem_wdata=0, dmem_mbe=0, stall=0, load_data=0, done=0, err=0.
REQ-034 SHALL, on a reset assertion during ACCESS, drop the request immediately and emit no done or err.

Verification
REQ-035 The bench SHALL cover: lb at addr 0x1003, dmem_rdata 0x80FF_FF_FF -> dmem_address 0x1000, load_data 0xFFFFFF80, done one cycle after completion.
REQ-036 The bench SHALL cover: sh at 0x2002, store_data 0x0000_BEEF -> dmem_mbe 4'b1100, dmem_wdata 0xBEEF0000, dmem_write held until dmem_resp.
REQ-037 The bench SHALL cover: lw at 0x3001 -> err pulse, no dmem_read, stall 0.
REQ-038 The bench SHALL cover: lhu at 0x4002, dmem_resp delayed 5 cycles, dmem_rdata 0x9ABC_1234 -> stall high 6 cycles, load_data 0x00009ABC.
REQ-039 The bench SHALL cover: RESP_TIMEOUT=4, no dmem_resp -> request dropped after 4 ACCESS cycles, err pulse, no done.
REQ-040 The bench SHALL cover: rst low in ACCESS cycle 2 -> all outputs 0 asynchronously, state IDLE, later dmem_resp ignored.
